// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state and transaction-owner types for mem_arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic {OWN_INS, OWN_DAT} owner_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and backing-memory buses of the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ins_req;
    logic [ADDR_W-1:0] ins_addr;
    logic              ins_gnt;
    logic              ins_rvalid;
    logic [DATA_W-1:0] ins_rdata;
    logic              dat_req;
    logic              dat_we;
    logic [ADDR_W-1:0] dat_addr;
    logic [DATA_W-1:0] dat_wdata;
    logic              dat_gnt;
    logic              dat_rvalid;
    logic [DATA_W-1:0] dat_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ins_req, ins_addr, dat_req, dat_we, dat_addr, dat_wdata,
               mem_gnt, mem_rvalid, mem_rdata,
        output ins_gnt, ins_rvalid, ins_rdata, dat_gnt, dat_rvalid, dat_rdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output ins_req, ins_addr, dat_req, dat_we, dat_addr, dat_wdata,
               mem_gnt, mem_rvalid, mem_rdata,
        input  ins_gnt, ins_rvalid, ins_rdata, dat_gnt, dat_rvalid, dat_rdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: data-priority winner select with a saturating fetch-starvation counter.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_ins_req,
    input  logic   i_dat_req,
    input  logic   i_grant,
    output owner_t o_winner,
    output logic   o_any_req
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] r_starve_cnt;
    logic          w_starved;

    assign w_starved = r_starve_cnt == CW'(STARVE_MAX);
    assign o_any_req = i_ins_req | i_dat_req;
    assign o_winner  = (i_dat_req && !(i_ins_req && w_starved)) ? OWN_DAT : OWN_INS;

    always_ff @(posedge clk) begin
        if (rst)
            r_starve_cnt <= '0;
        else if (i_grant && o_any_req) begin
            if (o_winner == OWN_INS)
                r_starve_cnt <= '0;
            else if (i_ins_req && !w_starved)
                r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and data paths,
// one outstanding transaction at a time, response routed back to its owner.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    state_t            r_state, w_next;
    owner_t            r_owner, w_winner;
    logic              w_any, w_take, w_resp;
    logic              r_we, r_ins_rvalid, r_dat_rvalid;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_ins_rdata, r_dat_rdata;

    mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .clk       (clk),
        .rst       (rst),
        .i_ins_req (bus.ins_req),
        .i_dat_req (bus.dat_req),
        .i_grant   (w_take),
        .o_winner  (w_winner),
        .o_any_req (w_any)
    );

    // Grants are suppressed during reset so nothing is accepted that reset would drop.
    assign w_take = (r_state == IDLE) && w_any && !rst;
    assign w_resp = (r_state == WAIT) && bus.mem_rvalid;

    always_comb begin
        w_next = r_state;
        if (w_take)
            w_next = ISSUE;
        else if (r_state == ISSUE && bus.mem_gnt)
            w_next = WAIT;
        else if (w_resp)
            w_next = IDLE;
        bus.ins_gnt = w_take && (w_winner == OWN_INS);
        bus.dat_gnt = w_take && (w_winner == OWN_DAT);
        bus.mem_req = r_state == ISSUE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner      <= OWN_INS;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_ins_rvalid <= 1'b0;
            r_dat_rvalid <= 1'b0;
            r_ins_rdata  <= '0;
            r_dat_rdata  <= '0;
        end else begin
            r_ins_rvalid <= w_resp && (r_owner == OWN_INS);
            r_dat_rvalid <= w_resp && (r_owner == OWN_DAT);
            if (w_take) begin
                r_owner <= w_winner;
                r_we    <= (w_winner == OWN_DAT) && bus.dat_we;
                r_addr  <= (w_winner == OWN_DAT) ? bus.dat_addr : bus.ins_addr;
                r_wdata <= (w_winner == OWN_DAT) ? bus.dat_wdata : '0;
            end
            if (w_resp && r_owner == OWN_INS)
                r_ins_rdata <= bus.mem_rdata;
            if (w_resp && r_owner == OWN_DAT)
                r_dat_rdata <= r_we ? '0 : bus.mem_rdata;
        end
    end

    assign bus.mem_we     = r_we;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_wdata  = r_wdata;
    assign bus.ins_rvalid = r_ins_rvalid;
    assign bus.ins_rdata  = r_ins_rdata;
    assign bus.dat_rvalid = r_dat_rvalid;
    assign bus.dat_rdata  = r_dat_rdata;
endmodule
